// File: rtl/bitmap_read_arbiter_if.sv
// rtl/bitmap_read_arbiter_if.sv - requester and bitmap-store signal bundle for the read arbiter
interface bitmap_read_arbiter_if #(
  parameter int ROW_ADDR_W = 5,
  parameter int DATA_W     = 32
);
  logic                  r1_req;
  logic [ROW_ADDR_W-1:0] r1_row;
  logic                  r1_ack;
  logic                  r1_valid;
  logic [DATA_W-1:0]     r1_data;

  logic                  r2_req;
  logic [ROW_ADDR_W-1:0] r2_row;
  logic                  r2_ack;
  logic                  r2_valid;
  logic [DATA_W-1:0]     r2_data;

  logic                  mem_rd_en;
  logic [ROW_ADDR_W-1:0] mem_rd_row;
  logic [DATA_W-1:0]     mem_rd_data;

  // master is the environment: both requesters plus the single-port store
  modport master (
    output r1_req, r1_row, r2_req, r2_row, mem_rd_data,
    input  r1_ack, r1_valid, r1_data, r2_ack, r2_valid, r2_data, mem_rd_en, mem_rd_row
  );

  modport slave (
    input  r1_req, r1_row, r2_req, r2_row, mem_rd_data,
    output r1_ack, r1_valid, r1_data, r2_ack, r2_valid, r2_data, mem_rd_en, mem_rd_row
  );
endinterface

// File: rtl/bitmap_read_arbiter.sv
// rtl/bitmap_read_arbiter.sv - two-requester arbiter sharing one single-port bitmap row store
module bitmap_read_arbiter #(
  parameter int ROW_ADDR_W  = 5,
  parameter int DATA_W      = 32,
  parameter int PRIO_MODE   = 0,
  parameter int R2_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  bitmap_read_arbiter_if.slave  bus
);
  localparam logic [7:0] WAIT_LIMIT = 8'(R2_MAX_WAIT);

  logic       r1_elig;
  logic       r2_elig;
  logic       grant_r1;
  logic       grant_r2;
  logic       last_r2;
  logic [7:0] wait_cnt;
  logic       tag1_vld;
  logic       tag1_r2;
  logic       tag2_vld;
  logic       tag2_r2;

  // A requester being acked this cycle still has req high; it must not win again.
  assign r1_elig = bus.r1_req && !bus.r1_ack;
  assign r2_elig = bus.r2_req && !bus.r2_ack;

  always_comb begin
    grant_r1 = 1'b0;
    grant_r2 = 1'b0;
    if (PRIO_MODE == 0) begin
      if (r1_elig && r2_elig) begin
        grant_r1 = last_r2;
        grant_r2 = !last_r2;
      end else begin
        grant_r1 = r1_elig;
        grant_r2 = r2_elig;
      end
    end else begin
      if (r2_elig && (!r1_elig || wait_cnt == WAIT_LIMIT)) begin
        grant_r2 = 1'b1;
      end else begin
        grant_r1 = r1_elig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.r1_ack     <= 1'b0;
      bus.r2_ack     <= 1'b0;
      bus.r1_valid   <= 1'b0;
      bus.r2_valid   <= 1'b0;
      bus.r1_data    <= {DATA_W{1'b0}};
      bus.r2_data    <= {DATA_W{1'b0}};
      bus.mem_rd_en  <= 1'b0;
      bus.mem_rd_row <= {ROW_ADDR_W{1'b0}};
      last_r2        <= 1'b1;
      wait_cnt       <= 8'd0;
      tag1_vld       <= 1'b0;
      tag1_r2        <= 1'b0;
      tag2_vld       <= 1'b0;
      tag2_r2        <= 1'b0;
    end else begin
      bus.r1_ack    <= grant_r1;
      bus.r2_ack    <= grant_r2;
      bus.mem_rd_en <= grant_r1 || grant_r2;
      if (grant_r1) begin
        bus.mem_rd_row <= bus.r1_row;
      end else if (grant_r2) begin
        bus.mem_rd_row <= bus.r2_row;
      end
      if (grant_r1 || grant_r2) begin
        last_r2 <= grant_r2;
      end

      if (!bus.r2_req || grant_r2) begin
        wait_cnt <= 8'd0;
      end else if (r2_elig && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // Owner tag rides with the read: stage 1 = strobe cycle, stage 2 = data cycle.
      tag1_vld <= grant_r1 || grant_r2;
      tag1_r2  <= grant_r2;
      tag2_vld <= tag1_vld;
      tag2_r2  <= tag1_r2;

      bus.r1_valid <= tag2_vld && !tag2_r2;
      bus.r2_valid <= tag2_vld && tag2_r2;
      if (tag2_vld && !tag2_r2) begin
        bus.r1_data <= bus.mem_rd_data;
      end
      if (tag2_vld && tag2_r2) begin
        bus.r2_data <= bus.mem_rd_data;
      end
    end
  end
endmodule

// File: tb/tb_bitmap_read_arbiter.sv
// tb/tb_bitmap_read_arbiter.sv - directed vector bench for bitmap_read_arbiter
module tb_bitmap_read_arbiter;
  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  bitmap_read_arbiter_if #(.ROW_ADDR_W(5), .DATA_W(32)) bus0 ();
  bitmap_read_arbiter_if #(.ROW_ADDR_W(5), .DATA_W(32)) bus1 ();

  bitmap_read_arbiter #(.ROW_ADDR_W(5), .DATA_W(32), .PRIO_MODE(0), .R2_MAX_WAIT(8)) dut0 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus0)
  );

  bitmap_read_arbiter #(.ROW_ADDR_W(5), .DATA_W(32), .PRIO_MODE(1), .R2_MAX_WAIT(8)) dut1 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus1)
  );

  function automatic logic [31:0] mem_fn(logic [4:0] row);
    return (row == 5'd5) ? 32'hA5A5_0F0F : {24'hC0FFEE, 3'b000, row};
  endfunction

  // Single-port store: data one cycle after the strobe.
  always @(posedge clk) begin
    if (bus0.mem_rd_en) bus0.mem_rd_data <= mem_fn(bus0.mem_rd_row);
    if (bus1.mem_rd_en) bus1.mem_rd_data <= mem_fn(bus1.mem_rd_row);
  end

  typedef struct {
    logic        rstn;
    logic        r1_req;
    logic [4:0]  r1_row;
    logic        r2_req;
    logic [4:0]  r2_row;
    logic        r1_ack;
    logic        r2_ack;
    logic        en;
    logic [4:0]  row;
    logic        r1_v;
    logic        r2_v;
    logic [31:0] r1_d;
    logic [31:0] r2_d;
  } vec_t;

  function automatic vec_t mk(logic rs, logic q1, logic [4:0] w1, logic q2, logic [4:0] w2,
                              logic a1, logic a2, logic en, logic [4:0] row,
                              logic v1, logic v2, logic [31:0] d1, logic [31:0] d2);
    vec_t v;
    v.rstn = rs; v.r1_req = q1; v.r1_row = w1; v.r2_req = q2; v.r2_row = w2;
    v.r1_ack = a1; v.r2_ack = a2; v.en = en; v.row = row;
    v.r1_v = v1; v.r2_v = v2; v.r1_d = d1; v.r2_d = d2;
    return v;
  endfunction

  int total = 0;
  int passed = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  localparam int NV = 31;
  vec_t vecs[NV];

  initial begin
    logic [31:0] z;
    logic [31:0] d1, d2, d3, d5, d6, d9;
    bit found;
    z  = 32'h0;
    d1 = mem_fn(5'd1); d2 = mem_fn(5'd2); d3 = mem_fn(5'd3);
    d5 = 32'hA5A5_0F0F; d6 = mem_fn(5'd6); d9 = mem_fn(5'd9);

    vecs[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, z,  z);
    vecs[1]  = mk(1, 1, 5, 0, 0,  1, 0, 1, 5,  0, 0, z,  z);
    vecs[2]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 5,  0, 0, z,  z);
    vecs[3]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 5,  1, 0, d5, z);
    vecs[4]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 5,  0, 0, d5, z);
    vecs[5]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, z,  z);
    vecs[6]  = mk(1, 1, 1, 1, 2,  1, 0, 1, 1,  0, 0, z,  z);
    vecs[7]  = mk(1, 1, 1, 1, 2,  0, 1, 1, 2,  0, 0, z,  z);
    vecs[8]  = mk(1, 1, 1, 1, 2,  1, 0, 1, 1,  1, 0, d1, z);
    vecs[9]  = mk(1, 1, 1, 1, 2,  0, 1, 1, 2,  0, 1, d1, d2);
    vecs[10] = mk(1, 0, 0, 0, 0,  0, 0, 0, 2,  1, 0, d1, d2);
    vecs[11] = mk(1, 0, 0, 0, 0,  0, 0, 0, 2,  0, 1, d1, d2);
    vecs[12] = mk(1, 0, 0, 0, 0,  0, 0, 0, 2,  0, 0, d1, d2);
    vecs[13] = mk(1, 1, 3, 0, 0,  1, 0, 1, 3,  0, 0, d1, d2);
    vecs[14] = mk(1, 1, 3, 0, 0,  0, 0, 0, 3,  0, 0, d1, d2);
    vecs[15] = mk(1, 1, 3, 0, 0,  1, 0, 1, 3,  1, 0, d3, d2);
    vecs[16] = mk(1, 1, 3, 0, 0,  0, 0, 0, 3,  0, 0, d3, d2);
    vecs[17] = mk(1, 0, 0, 0, 0,  0, 0, 0, 3,  1, 0, d3, d2);
    vecs[18] = mk(1, 0, 0, 0, 0,  0, 0, 0, 3,  0, 0, d3, d2);
    vecs[19] = mk(1, 1, 4, 1, 6,  0, 1, 1, 6,  0, 0, d3, d2);
    vecs[20] = mk(1, 0, 0, 0, 0,  0, 0, 0, 6,  0, 0, d3, d2);
    vecs[21] = mk(1, 0, 0, 0, 0,  0, 0, 0, 6,  0, 1, d3, d6);
    vecs[22] = mk(1, 0, 0, 0, 0,  0, 0, 0, 6,  0, 0, d3, d6);
    vecs[23] = mk(1, 0, 0, 1, 7,  0, 1, 1, 7,  0, 0, d3, d6);
    vecs[24] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, z,  z);
    vecs[25] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, z,  z);
    vecs[26] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, z,  z);
    vecs[27] = mk(1, 0, 0, 1, 9,  0, 1, 1, 9,  0, 0, z,  z);
    vecs[28] = mk(1, 0, 0, 0, 0,  0, 0, 0, 9,  0, 0, z,  z);
    vecs[29] = mk(1, 0, 0, 0, 0,  0, 0, 0, 9,  0, 1, z,  d9);
    vecs[30] = mk(1, 0, 0, 0, 0,  0, 0, 0, 9,  0, 0, z,  d9);

    rstn = 1'b0;
    bus0.r1_req = 1'b0; bus0.r1_row = '0; bus0.r2_req = 1'b0; bus0.r2_row = '0;
    bus1.r1_req = 1'b0; bus1.r1_row = '0; bus1.r2_req = 1'b0; bus1.r2_row = '0;
    #1;

    // Each row's inputs are sampled at one edge; its expectations are the outputs after it.
    for (int i = 0; i < NV; i++) begin
      rstn        = vecs[i].rstn;
      bus0.r1_req = vecs[i].r1_req;
      bus0.r1_row = vecs[i].r1_row;
      bus0.r2_req = vecs[i].r2_req;
      bus0.r2_row = vecs[i].r2_row;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_r1_ack", i),   32'(bus0.r1_ack),     32'(vecs[i].r1_ack));
      check($sformatf("v%0d_r2_ack", i),   32'(bus0.r2_ack),     32'(vecs[i].r2_ack));
      check($sformatf("v%0d_rd_en", i),    32'(bus0.mem_rd_en),  32'(vecs[i].en));
      check($sformatf("v%0d_rd_row", i),   32'(bus0.mem_rd_row), 32'(vecs[i].row));
      check($sformatf("v%0d_r1_valid", i), 32'(bus0.r1_valid),   32'(vecs[i].r1_v));
      check($sformatf("v%0d_r2_valid", i), 32'(bus0.r2_valid),   32'(vecs[i].r2_v));
      check($sformatf("v%0d_r1_data", i),  bus0.r1_data,         vecs[i].r1_d);
      check($sformatf("v%0d_r2_data", i),  bus0.r2_data,         vecs[i].r2_d);
    end

    // Fixed-priority instance: r1 wins the tie, r2 still gets in within the wait bound.
    bus1.r1_req = 1'b1; bus1.r1_row = 5'd10;
    bus1.r2_req = 1'b1; bus1.r2_row = 5'd11;
    @(posedge clk);
    #1;
    check("m1_first_r1_ack", 32'(bus1.r1_ack), 32'd1);
    check("m1_first_r2_ack", 32'(bus1.r2_ack), 32'd0);

    found = 1'b0;
    for (int k = 2; k <= 9 && !found; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("m1_no_double_ack_%0d", k), 32'(bus1.r1_ack && bus1.r2_ack), 32'd0);
      if (bus1.r2_ack) found = 1'b1;
    end
    check("m1_r2_guard_ack", 32'(found), 32'd1);

    bus1.r2_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3 && !found; k++) begin
      @(posedge clk);
      #1;
      if (bus1.r1_ack) found = 1'b1;
    end
    check("m1_r1_resume", 32'(found), 32'd1);

    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (bus1.r2_valid) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("m1_r2_valid_seen", 32'(found), 32'd1);
    check("m1_r2_data", bus1.r2_data, mem_fn(5'd11));

    bus1.r1_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("m1_idle_rd_en", 32'(bus1.mem_rd_en), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
